gesture_tracker: RTL

//  Downstream of the first-red-point detector. Consumes the per-frame detect pulse and X/Y coordinate.

---
 rtl/gesture_tracker_pkg.sv | 30 +++
 rtl/gesture_tracker_if.sv | 26 ++
 rtl/gesture_tracker_delta_classify.sv | 40 ++++
 rtl/gesture_tracker.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/gesture_tracker_pkg.sv
// Shared types and widths for the gesture tracker: FSM states, gesture codes,
// coordinate/delta widths and a magnitude helper for signed deltas.
package tracker_pkg;

  localparam int POS_W   = 16;
  localparam int DELTA_W = 17;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    GEST_NONE  = 3'd0,
    GEST_LEFT  = 3'd1,
    GEST_RIGHT = 3'd2,
    GEST_UP    = 3'd3,
    GEST_DOWN  = 3'd4
  } gesture_e;

  // Deltas come from zero-extended 16-bit positions, so the magnitude always fits in DELTA_W bits.
  function automatic logic [DELTA_W-1:0] abs_delta(input logic signed [DELTA_W-1:0] d);
    logic signed [DELTA_W-1:0] neg;
    neg = -d;
    return d[DELTA_W-1] ? $unsigned(neg) : $unsigned(d);
  endfunction

endpackage

// File: rtl/gesture_tracker_if.sv
// Detector-to-tracker handshake and gesture result bus. The master drives the
// per-frame detect/position/end-of-frame inputs; the tracker is the slave.
interface gesture_tracker_if;
  import tracker_pkg::*;

  logic                      i_detect;
  logic [POS_W-1:0]          i_X_pos;
  logic [POS_W-1:0]          i_Y_pos;
  logic                      i_end_frame;
  logic                      o_valid;
  logic [2:0]                o_gesture;
  logic signed [DELTA_W-1:0] o_dx;
  logic signed [DELTA_W-1:0] o_dy;
  logic                      o_tracking;

  modport master (
    output i_detect, i_X_pos, i_Y_pos, i_end_frame,
    input  o_valid, o_gesture, o_dx, o_dy, o_tracking
  );

  modport slave (
    input  i_detect, i_X_pos, i_Y_pos, i_end_frame,
    output o_valid, o_gesture, o_dx, o_dy, o_tracking
  );

endinterface

// File: rtl/gesture_tracker_delta_classify.sv
// Combinational displacement classifier: signed deltas from the anchor, a
// threshold hit flag and the dominant-axis gesture code (ties go to X).
module delta_classify
  import tracker_pkg::*;
#(
  parameter int MOVE_TH = 64
) (
  input  logic [POS_W-1:0]          cur_x_i,
  input  logic [POS_W-1:0]          cur_y_i,
  input  logic [POS_W-1:0]          anchor_x_i,
  input  logic [POS_W-1:0]          anchor_y_i,
  output logic signed [DELTA_W-1:0] dx_o,
  output logic signed [DELTA_W-1:0] dy_o,
  output logic                      hit_o,
  output gesture_e                  gesture_o
);

  localparam logic [DELTA_W-1:0] TH = DELTA_W'(MOVE_TH);

  logic [DELTA_W-1:0] adx;
  logic [DELTA_W-1:0] ady;
  logic [DELTA_W-1:0] amax;
  logic               x_dom;

  always_comb begin
    dx_o      = $signed({1'b0, cur_x_i}) - $signed({1'b0, anchor_x_i});
    dy_o      = $signed({1'b0, cur_y_i}) - $signed({1'b0, anchor_y_i});
    adx       = abs_delta(dx_o);
    ady       = abs_delta(dy_o);
    x_dom     = (adx >= ady);
    amax      = x_dom ? adx : ady;
    hit_o     = (amax >= TH);
    gesture_o = GEST_NONE;
    if (hit_o) begin
      if (x_dom) gesture_o = dx_o[DELTA_W-1] ? GEST_LEFT : GEST_RIGHT;
      else       gesture_o = dy_o[DELTA_W-1] ? GEST_UP   : GEST_DOWN;
    end
  end

endmodule

// File: rtl/gesture_tracker.sv
// Frame-level red-point tracker emitting LEFT/RIGHT/UP/DOWN gesture pulses.
// Optional macro TRACK_FILTER_EN averages the current and previous position in TRACK.
module gesture_tracker
  import tracker_pkg::*;
#(
  parameter int MOVE_TH     = 64,
  parameter int MISS_LIMIT  = 4,
  parameter int MAX_AGE     = 30,
  parameter int HOLD_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst,
  gesture_tracker_if.slave bus
);

  localparam logic [CNT_W-1:0] MISS_LIM = CNT_W'(MISS_LIMIT);
  localparam logic [CNT_W-1:0] AGE_LIM  = CNT_W'(MAX_AGE);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_FRAMES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_e                    state_q;
  logic                      seen_q, seen_d;
  logic [POS_W-1:0]          cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [POS_W-1:0]          anchor_x_q, anchor_y_q;
  logic [CNT_W-1:0]          age_q, miss_q, hold_q;
  logic                      valid_q;
  gesture_e                  gesture_q;
  logic signed [DELTA_W-1:0] dx_q, dy_q;

  logic                      frame_seen;
  logic [POS_W-1:0]          frame_x, frame_y;
  logic [POS_W-1:0]          cmp_x, cmp_y;
  logic signed [DELTA_W-1:0] dx, dy;
  logic                      hit;
  gesture_e                  gest;

  // A detect arriving with the end-of-frame pulse still belongs to the closing frame.
  always_comb begin
    frame_seen = seen_q | bus.i_detect;
    frame_x    = seen_q ? cur_x_q : bus.i_X_pos;
    frame_y    = seen_q ? cur_y_q : bus.i_Y_pos;
    seen_d     = bus.i_end_frame ? 1'b0 : frame_seen;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    if (bus.i_detect && !seen_q) begin
      cur_x_d = bus.i_X_pos;
      cur_y_d = bus.i_Y_pos;
    end
  end

`ifdef TRACK_FILTER_EN
  logic [POS_W-1:0] prev_x_q, prev_y_q;
  logic [POS_W:0]   sum_x, sum_y;

  always_comb begin
    sum_x = {1'b0, frame_x} + {1'b0, prev_x_q};
    sum_y = {1'b0, frame_y} + {1'b0, prev_y_q};
    cmp_x = sum_x[POS_W:1];
    cmp_y = sum_y[POS_W:1];
  end
`else
  always_comb begin
    cmp_x = frame_x;
    cmp_y = frame_y;
  end
`endif

  delta_classify #(
    .MOVE_TH (MOVE_TH)
  ) u_classify (
    .cur_x_i    (cmp_x),
    .cur_y_i    (cmp_y),
    .anchor_x_i (anchor_x_q),
    .anchor_y_i (anchor_y_q),
    .dx_o       (dx),
    .dy_o       (dy),
    .hit_o      (hit),
    .gesture_o  (gest)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seen_q  <= 1'b0;
      cur_x_q <= '0;
      cur_y_q <= '0;
    end else begin
      seen_q  <= seen_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      anchor_x_q <= '0;
      anchor_y_q <= '0;
      age_q      <= '0;
      miss_q     <= '0;
      hold_q     <= '0;
      valid_q    <= 1'b0;
      gesture_q  <= GEST_NONE;
      dx_q       <= '0;
      dy_q       <= '0;
`ifdef TRACK_FILTER_EN
      prev_x_q   <= '0;
      prev_y_q   <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (bus.i_end_frame) begin
        case (state_q)
          IDLE: begin
            if (frame_seen) begin
              anchor_x_q <= frame_x;
              anchor_y_q <= frame_y;
              age_q      <= '0;
              miss_q     <= '0;
`ifdef TRACK_FILTER_EN
              prev_x_q   <= frame_x;
              prev_y_q   <= frame_y;
`endif
              state_q    <= TRACK;
            end
          end
          TRACK: begin
            if (frame_seen) begin
`ifdef TRACK_FILTER_EN
              prev_x_q <= frame_x;
              prev_y_q <= frame_y;
`endif
              if (hit) begin
                valid_q   <= 1'b1;
                gesture_q <= gest;
                dx_q      <= dx;
                dy_q      <= dy;
                hold_q    <= '0;
                state_q   <= HOLD;
              end else begin
                miss_q <= '0;
                // A stale anchor is re-based so slow drift never accumulates into a gesture.
                if (sat_inc(age_q) >= AGE_LIM) begin
                  anchor_x_q <= cmp_x;
                  anchor_y_q <= cmp_y;
                  age_q      <= '0;
                end else begin
                  age_q <= sat_inc(age_q);
                end
              end
            end else begin
              miss_q <= sat_inc(miss_q);
              if (sat_inc(miss_q) >= MISS_LIM) state_q <= IDLE;
            end
          end
          HOLD: begin
            hold_q <= sat_inc(hold_q);
            if (sat_inc(hold_q) >= HOLD_LIM) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_gesture  = gesture_q;
  assign bus.o_dx       = dx_q;
  assign bus.o_dy       = dy_q;
  assign bus.o_tracking = (state_q == TRACK);

endmodule
